// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with a circular return-address stack and a sticky halt state.
// Define RAS_CHECK_EN to check RAS predictions against the register-file return address.
module pc_ras_unit #(
  parameter int unsigned     PC_W       = 16,
  parameter int unsigned     INST_W     = 16,
  parameter int unsigned     BR_OFF_W   = 9,
  parameter int unsigned     CALL_OFF_W = 12,
  parameter int unsigned     RAS_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic                         hlt,
  input  logic                         branch,
  input  logic                         call,
  input  logic                         ret,
  input  logic [PC_W-1:0]              id_pc_inc,
  input  logic [INST_W-1:0]            id_inst,
  input  logic [PC_W-1:0]              ret_reg_data,
  output logic [PC_W-1:0]              curr_pc,
  output logic [PC_W-1:0]              pc_inc,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_mismatch
);

  localparam int unsigned     PtrW    = $clog2(RAS_DEPTH);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic              push;
  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PC_W-1:0]   ras_top;

  logic signed [BR_OFF_W-1:0]   br_field;
  logic signed [CALL_OFF_W-1:0] call_field;
  logic [PC_W-1:0]              br_off;
  logic [PC_W-1:0]              call_off;
  logic                         unused_inst;

`ifdef RAS_CHECK_EN
  logic mismatch_q, mismatch_d;
`endif

  // Signed size casts sign-extend the offset fields to the PC width.
  assign br_field    = id_inst[BR_OFF_W-1:0];
  assign call_field  = id_inst[CALL_OFF_W-1:0];
  assign br_off      = PC_W'(br_field);
  assign call_off    = PC_W'(call_field);
  assign unused_inst = ^id_inst;

  assign ras_top = ras_mem[top_q];
  assign pc_inc  = pc_q + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    push    = 1'b0;
`ifdef RAS_CHECK_EN
    mismatch_d = 1'b0;
`endif
    if (state_q == StRun && we) begin
      if (hlt) begin
        state_d = StHalted;
      end else if (branch) begin
        pc_d = id_pc_inc + br_off;
      end else if (call) begin
        pc_d  = id_pc_inc + call_off;
        push  = 1'b1;
        // When full the write lands on the oldest entry and the count saturates.
        top_d = top_q + PtrW'(1);
        if (cnt_q != CntFull) cnt_d = cnt_q + CntW'(1);
      end else if (ret) begin
        if (cnt_q != '0) begin
          top_d = top_q - PtrW'(1);
          cnt_d = cnt_q - CntW'(1);
          pc_d  = ras_top;
`ifdef RAS_CHECK_EN
          if (ras_top != ret_reg_data) begin
            pc_d       = ret_reg_data;
            mismatch_d = 1'b1;
          end
`endif
        end else begin
          pc_d = ret_reg_data;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
    end
  end

  // Stack storage needs no reset; the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) ras_mem[top_d] <= id_pc_inc;
  end

`ifdef RAS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end
  assign ras_mismatch = mismatch_q;
`else
  assign ras_mismatch = 1'b0;
`endif

  assign curr_pc   = pc_q;
  assign halted    = (state_q == StHalted);
  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntFull);

endmodule
